// File: rtl/v_pipe_update_fwd.sv
`default_nettype none
// ============================================================================
// Module   : v_pipe_update_fwd
// Purpose  : Level-0 (best entry) list update pipeline. Each accepted update
//            does a read-modify-write of the per-product best state held in an
//            external state RAM. Writes still in flight are forwarded to the
//            modify stage, so same-product updates on consecutive cycles are
//            applied in arrival order. A level-0 notify is raised whenever a
//            product's best entry changes. After reset, an init sweep
//            invalidates every state entry before updates are accepted.
// Ports    : clk, rst (sync, active-high)
//            i_upd_*            update input, one per cycle, no backpressure
//            i_state_rdata      RAM read data {vld,key,size}, one cycle after ren
//            o_state_ren/raddr  RAM read port (combinational from stage 1)
//            o_state_*_r        RAM write port (registered)
//            o_lv0_*_r          level-0 change notify
//            o_sN_upd_*_r       per-stage occupancy, N = 1..4
//            o_init_done_r      init sweep complete
// Options  : define V_PIPE_UPDATE_FWD_STATS_EN to add o_stat_upd_cnt_r and
//            o_stat_ntf_cnt_r (update and notify counters).
// Revision : 1.0 - initial release
// ============================================================================
module v_pipe_update_fwd #(
  parameter int ID_W       = 4,
  parameter int KEY_W      = 16,
  parameter int SIZE_W     = 16,
  parameter int KEY_ASCEND = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_upd_vld,
  input  logic [ID_W-1:0]            i_upd_prod_id,
  input  logic [1:0]                 i_upd_cmd,
  input  logic [KEY_W-1:0]           i_upd_key,
  input  logic [SIZE_W-1:0]          i_upd_size,
  input  logic [KEY_W+SIZE_W:0]      i_state_rdata,
  output logic                       o_state_ren,
  output logic [ID_W-1:0]            o_state_raddr,
  output logic                       o_state_wen_r,
  output logic [ID_W-1:0]            o_state_waddr_r,
  output logic [KEY_W+SIZE_W:0]      o_state_wdata_r,
  output logic                       o_lv0_vld_r,
  output logic [ID_W-1:0]            o_lv0_prod_id_r,
  output logic [KEY_W-1:0]           o_lv0_key_r,
  output logic [SIZE_W-1:0]          o_lv0_size_r,
  output logic                       o_s1_upd_vld_r,
  output logic [ID_W-1:0]            o_s1_upd_prod_id_r,
  output logic                       o_s2_upd_vld_r,
  output logic [ID_W-1:0]            o_s2_upd_prod_id_r,
  output logic                       o_s3_upd_vld_r,
  output logic [ID_W-1:0]            o_s3_upd_prod_id_r,
  output logic                       o_s4_upd_vld_r,
  output logic [ID_W-1:0]            o_s4_upd_prod_id_r,
`ifdef V_PIPE_UPDATE_FWD_STATS_EN
  output logic [31:0]                o_stat_upd_cnt_r,
  output logic [31:0]                o_stat_ntf_cnt_r,
`endif
  output logic                       o_init_done_r
);

  localparam int ST_W = 1 + KEY_W + SIZE_W;
  localparam logic [1:0] CMD_CLR = 2'd0;
  localparam logic [1:0] CMD_ADD = 2'd1;
  localparam logic [1:0] CMD_DEL = 2'd2;
  localparam logic [ID_W-1:0] ID_ONE = {{(ID_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   init_addr;

  logic [1:0]        s1_cmd, s2_cmd;
  logic [KEY_W-1:0]  s1_key, s2_key;
  logic [SIZE_W-1:0] s1_size, s2_size;
  logic [ST_W-1:0]   s4_wdata;

  logic [ST_W-1:0]   old_state, next_state;
  logic              old_v;
  logic [KEY_W-1:0]  old_k;
  logic [SIZE_W-1:0] old_s;
  logic [SIZE_W:0]   size_sum;
  logic [SIZE_W-1:0] size_sat;
  logic              key_better, key_eq, changed;

  assign o_state_ren   = o_s1_upd_vld_r;
  assign o_state_raddr = o_s1_upd_prod_id_r;

  // The RAM read for the update in S2 was issued before the S3 write (and,
  // with read-old, the S4 write) committed, so those writes must override it.
  // S3 is the younger of the two and wins.
  always_comb begin
    old_state = i_state_rdata;
    if (o_s3_upd_vld_r && (o_s3_upd_prod_id_r == o_s2_upd_prod_id_r)) begin
      old_state = o_state_wdata_r;
    end else if (o_s4_upd_vld_r && (o_s4_upd_prod_id_r == o_s2_upd_prod_id_r)) begin
      old_state = s4_wdata;
    end
  end

  assign {old_v, old_k, old_s} = old_state;
  assign key_eq   = (s2_key == old_k);
  assign size_sum = {1'b0, old_s} + {1'b0, s2_size};
  assign size_sat = size_sum[SIZE_W] ? {SIZE_W{1'b1}} : size_sum[SIZE_W-1:0];

  generate
    if (KEY_ASCEND != 0) begin : g_ask_side
      assign key_better = (s2_key < old_k);
    end else begin : g_bid_side
      assign key_better = (s2_key > old_k);
    end
  endgenerate

  always_comb begin
    next_state = old_state;
    case (s2_cmd)
      CMD_CLR: next_state = '0;
      CMD_ADD: begin
        if (!old_v || key_better) begin
          next_state = {1'b1, s2_key, s2_size};
        end else if (key_eq) begin
          next_state = {1'b1, old_k, size_sat};
        end
      end
      CMD_DEL: begin
        if (old_v && key_eq) begin
          if (s2_size >= old_s) next_state = '0;
          else                  next_state = {1'b1, old_k, old_s - s2_size};
        end
      end
      default: next_state = {1'b1, s2_key, s2_size};  // REP
    endcase
  end

  assign changed = (next_state != old_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_INIT;
      init_addr          <= '0;
      o_init_done_r      <= 1'b0;
      o_state_wen_r      <= 1'b0;
      o_state_waddr_r    <= '0;
      o_state_wdata_r    <= '0;
      o_lv0_vld_r        <= 1'b0;
      o_lv0_prod_id_r    <= '0;
      o_lv0_key_r        <= '0;
      o_lv0_size_r       <= '0;
      o_s1_upd_vld_r     <= 1'b0;
      o_s1_upd_prod_id_r <= '0;
      o_s2_upd_vld_r     <= 1'b0;
      o_s2_upd_prod_id_r <= '0;
      o_s3_upd_vld_r     <= 1'b0;
      o_s3_upd_prod_id_r <= '0;
      o_s4_upd_vld_r     <= 1'b0;
      o_s4_upd_prod_id_r <= '0;
      s1_cmd             <= '0;
      s1_key             <= '0;
      s1_size            <= '0;
      s2_cmd             <= '0;
      s2_key             <= '0;
      s2_size            <= '0;
      s4_wdata           <= '0;
    end else begin
      // Stage advance; updates are only admitted once the sweep is done.
      o_s1_upd_vld_r     <= i_upd_vld && o_init_done_r;
      o_s1_upd_prod_id_r <= i_upd_prod_id;
      s1_cmd             <= i_upd_cmd;
      s1_key             <= i_upd_key;
      s1_size            <= i_upd_size;
      o_s2_upd_vld_r     <= o_s1_upd_vld_r;
      o_s2_upd_prod_id_r <= o_s1_upd_prod_id_r;
      s2_cmd             <= s1_cmd;
      s2_key             <= s1_key;
      s2_size            <= s1_size;
      o_s3_upd_vld_r     <= o_s2_upd_vld_r;
      o_s3_upd_prod_id_r <= o_s2_upd_prod_id_r;
      o_s4_upd_vld_r     <= o_s3_upd_vld_r;
      o_s4_upd_prod_id_r <= o_s3_upd_prod_id_r;
      s4_wdata           <= o_state_wdata_r;

      // Notify fields hold their last value between pulses.
      o_lv0_vld_r <= o_s2_upd_vld_r && changed;
      if (o_s2_upd_vld_r && changed) begin
        o_lv0_prod_id_r <= o_s2_upd_prod_id_r;
        o_lv0_key_r     <= next_state[ST_W-1] ? next_state[KEY_W+SIZE_W-1:SIZE_W] : '0;
        o_lv0_size_r    <= next_state[ST_W-1] ? next_state[SIZE_W-1:0] : '0;
      end

      case (state)
        ST_INIT: begin
          o_state_wen_r   <= 1'b1;
          o_state_waddr_r <= init_addr;
          o_state_wdata_r <= '0;
          init_addr       <= init_addr + ID_ONE;
          if (init_addr == {ID_W{1'b1}}) state <= ST_RUN;
        end
        ST_RUN: begin
          o_init_done_r   <= 1'b1;
          o_state_wen_r   <= o_s2_upd_vld_r;
          o_state_waddr_r <= o_s2_upd_prod_id_r;
          o_state_wdata_r <= next_state;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef V_PIPE_UPDATE_FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_upd_cnt_r <= '0;
      o_stat_ntf_cnt_r <= '0;
    end else begin
      if (i_upd_vld && o_init_done_r) o_stat_upd_cnt_r <= o_stat_upd_cnt_r + 32'd1;
      if (o_lv0_vld_r)                o_stat_ntf_cnt_r <= o_stat_ntf_cnt_r + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_v_pipe_update_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_pipe_update_fwd
// Purpose  : Directed self-checking bench. Two instances share the update
//            stimulus: dut_a (bid side, KEY_ASCEND=0) and dut_b (ask side,
//            KEY_ASCEND=1), each with its own read-old state RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v_pipe_update_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_vld;
  logic [3:0]  upd_id;
  logic [1:0]  upd_cmd;
  logic [15:0] upd_key;
  logic [15:0] upd_size;

  logic [32:0] a_rdata, b_rdata;
  logic        a_ren, b_ren, a_wen, b_wen;
  logic [3:0]  a_raddr, b_raddr, a_waddr, b_waddr;
  logic [32:0] a_wdata, b_wdata;
  logic        a_lv, b_lv;
  logic [3:0]  a_lid, b_lid;
  logic [15:0] a_lkey, b_lkey, a_lsize, b_lsize;
  logic        a_s1v, a_s2v, a_s3v, a_s4v, b_s1v, b_s2v, b_s3v, b_s4v;
  logic [3:0]  a_s1i, a_s2i, a_s3i, a_s4i, b_s1i, b_s2i, b_s3i, b_s4i;
  logic        a_done, b_done;
`ifdef V_PIPE_UPDATE_FWD_STATS_EN
  logic [31:0] a_su, a_sn, b_su, b_sn;
`endif

  logic [32:0] mem_a [16];
  logic [32:0] mem_b [16];

  int n_cmp = 0;
  int n_err = 0;

  wire [37:0] wr_a = {a_wen, a_waddr, a_wdata};
  wire [37:0] wr_b = {b_wen, b_waddr, b_wdata};
  wire [36:0] nt_a = {a_lv, a_lid, a_lkey, a_lsize};
  wire [36:0] nt_b = {b_lv, b_lid, b_lkey, b_lsize};

  always #5 clk = ~clk;

  // State RAM models: read-old, write commits at the edge ending the wen cycle.
  always @(posedge clk) begin
    if (a_ren) a_rdata <= mem_a[a_raddr];
    if (a_wen) mem_a[a_waddr] <= a_wdata;
    if (b_ren) b_rdata <= mem_b[b_raddr];
    if (b_wen) mem_b[b_waddr] <= b_wdata;
  end

  v_pipe_update_fwd #(.ID_W(4), .KEY_W(16), .SIZE_W(16), .KEY_ASCEND(0)) dut_a (
    .clk(clk), .rst(rst),
    .i_upd_vld(upd_vld), .i_upd_prod_id(upd_id), .i_upd_cmd(upd_cmd),
    .i_upd_key(upd_key), .i_upd_size(upd_size), .i_state_rdata(a_rdata),
    .o_state_ren(a_ren), .o_state_raddr(a_raddr),
    .o_state_wen_r(a_wen), .o_state_waddr_r(a_waddr), .o_state_wdata_r(a_wdata),
    .o_lv0_vld_r(a_lv), .o_lv0_prod_id_r(a_lid), .o_lv0_key_r(a_lkey), .o_lv0_size_r(a_lsize),
    .o_s1_upd_vld_r(a_s1v), .o_s1_upd_prod_id_r(a_s1i),
    .o_s2_upd_vld_r(a_s2v), .o_s2_upd_prod_id_r(a_s2i),
    .o_s3_upd_vld_r(a_s3v), .o_s3_upd_prod_id_r(a_s3i),
    .o_s4_upd_vld_r(a_s4v), .o_s4_upd_prod_id_r(a_s4i),
`ifdef V_PIPE_UPDATE_FWD_STATS_EN
    .o_stat_upd_cnt_r(a_su), .o_stat_ntf_cnt_r(a_sn),
`endif
    .o_init_done_r(a_done)
  );

  v_pipe_update_fwd #(.ID_W(4), .KEY_W(16), .SIZE_W(16), .KEY_ASCEND(1)) dut_b (
    .clk(clk), .rst(rst),
    .i_upd_vld(upd_vld), .i_upd_prod_id(upd_id), .i_upd_cmd(upd_cmd),
    .i_upd_key(upd_key), .i_upd_size(upd_size), .i_state_rdata(b_rdata),
    .o_state_ren(b_ren), .o_state_raddr(b_raddr),
    .o_state_wen_r(b_wen), .o_state_waddr_r(b_waddr), .o_state_wdata_r(b_wdata),
    .o_lv0_vld_r(b_lv), .o_lv0_prod_id_r(b_lid), .o_lv0_key_r(b_lkey), .o_lv0_size_r(b_lsize),
    .o_s1_upd_vld_r(b_s1v), .o_s1_upd_prod_id_r(b_s1i),
    .o_s2_upd_vld_r(b_s2v), .o_s2_upd_prod_id_r(b_s2i),
    .o_s3_upd_vld_r(b_s3v), .o_s3_upd_prod_id_r(b_s3i),
    .o_s4_upd_vld_r(b_s4v), .o_s4_upd_prod_id_r(b_s4i),
`ifdef V_PIPE_UPDATE_FWD_STATS_EN
    .o_stat_upd_cnt_r(b_su), .o_stat_ntf_cnt_r(b_sn),
`endif
    .o_init_done_r(b_done)
  );

  task automatic drive(input logic v, input logic [3:0] id, input logic [1:0] cmd,
                       input logic [15:0] key, input logic [15:0] size);
    upd_vld = v; upd_id = id; upd_cmd = cmd; upd_key = key; upd_size = size;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 2'd0, 16'd0, 16'd0);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (3) nxt();
    n_cmp++;
    if ({wr_a, nt_a, a_done, a_ren, a_s1v, a_s2v, a_s3v, a_s4v} !== '0) begin
      n_err++; $display("FAIL reset_state_a actual=%h required=0",
                        {wr_a, nt_a, a_done, a_ren, a_s1v, a_s2v, a_s3v, a_s4v});
    end
    n_cmp++;
    if ({wr_b, nt_b, b_done, b_ren} !== '0) begin
      n_err++; $display("FAIL reset_state_b actual=%h required=0", {wr_b, nt_b, b_done, b_ren});
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nxt();
      n_cmp++;
      if ({wr_a, a_done, a_lv} !== {1'b1, 4'(i), 33'd0, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL init_write_%0d actual=%h required=%h", i,
                          {wr_a, a_done, a_lv}, {1'b1, 4'(i), 33'd0, 1'b0, 1'b0});
      end
    end
    nxt();
    n_cmp++;
    if ({a_done, a_wen, a_lv, b_done, b_wen} !== 5'b10010) begin
      n_err++; $display("FAIL init_done actual=%b required=10010", {a_done, a_wen, a_lv, b_done, b_wen});
    end
  endtask

  task automatic test_basic_add();
    drive(1'b1, 4'd3, 2'd1, 16'd100, 16'd5);
    nxt(); idle();
    n_cmp++;
    if ({a_ren, a_raddr} !== {1'b1, 4'd3}) begin
      n_err++; $display("FAIL basic_read actual=%h required=%h", {a_ren, a_raddr}, {1'b1, 4'd3});
    end
    nxt(); nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd3, 1'b1, 16'd100, 16'd5}) begin
      n_err++; $display("FAIL basic_write actual=%h required=%h", wr_a, {1'b1, 4'd3, 1'b1, 16'd100, 16'd5});
    end
    n_cmp++;
    if (nt_a !== {1'b1, 4'd3, 16'd100, 16'd5}) begin
      n_err++; $display("FAIL basic_notify actual=%h required=%h", nt_a, {1'b1, 4'd3, 16'd100, 16'd5});
    end
    nxt(); nxt();
  endtask

  task automatic test_clr();
    drive(1'b1, 4'd3, 2'd0, 16'd0, 16'd0);
    nxt(); idle(); nxt(); nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd3, 33'd0} || nt_a !== {1'b1, 4'd3, 32'd0}) begin
      n_err++; $display("FAIL clr actual=%h/%h required=%h/%h", wr_a, nt_a, {1'b1, 4'd3, 33'd0}, {1'b1, 4'd3, 32'd0});
    end
    nxt(); nxt();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd3, 2'd1, 16'd100, 16'd5);  nxt();
    drive(1'b1, 4'd3, 2'd1, 16'd100, 16'd7);  nxt();
    drive(1'b1, 4'd3, 2'd2, 16'd100, 16'd12); nxt();
    idle();
    n_cmp++;
    if ({a_s1v, a_s1i, a_s2v, a_s2i, a_s3v, a_s3i, a_s4v} !== {1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0}) begin
      n_err++; $display("FAIL b2b_occupancy actual=%h required=%h", {a_s1v, a_s1i, a_s2v, a_s2i, a_s3v, a_s3i, a_s4v},
                        {1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0});
    end
    n_cmp++;
    if (wr_a !== {1'b1, 4'd3, 1'b1, 16'd100, 16'd5} || nt_a !== {1'b1, 4'd3, 16'd100, 16'd5}) begin
      n_err++; $display("FAIL b2b_first actual=%h/%h required=%h/%h", wr_a, nt_a,
                        {1'b1, 4'd3, 1'b1, 16'd100, 16'd5}, {1'b1, 4'd3, 16'd100, 16'd5});
    end
    nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd3, 1'b1, 16'd100, 16'd12} || nt_a !== {1'b1, 4'd3, 16'd100, 16'd12}) begin
      n_err++; $display("FAIL b2b_second actual=%h/%h required=%h/%h", wr_a, nt_a,
                        {1'b1, 4'd3, 1'b1, 16'd100, 16'd12}, {1'b1, 4'd3, 16'd100, 16'd12});
    end
    nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd3, 33'd0} || nt_a !== {1'b1, 4'd3, 32'd0}) begin
      n_err++; $display("FAIL b2b_third actual=%h/%h required=%h/%h", wr_a, nt_a, {1'b1, 4'd3, 33'd0}, {1'b1, 4'd3, 32'd0});
    end
    n_cmp++;
    if (wr_b !== {1'b1, 4'd3, 33'd0} || nt_b !== {1'b1, 4'd3, 32'd0}) begin
      n_err++; $display("FAIL b2b_third_ask actual=%h/%h required=%h/%h", wr_b, nt_b, {1'b1, 4'd3, 33'd0}, {1'b1, 4'd3, 32'd0});
    end
    nxt(); nxt();
  endtask

  task automatic test_fwd_s4();
    drive(1'b1, 4'd7, 2'd3, 16'd50, 16'd1); nxt();
    idle(); nxt();
    drive(1'b1, 4'd7, 2'd1, 16'd40, 16'd9); nxt();
    idle();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd7, 1'b1, 16'd50, 16'd1} || nt_a !== {1'b1, 4'd7, 16'd50, 16'd1}) begin
      n_err++; $display("FAIL fwd_rep actual=%h/%h required=%h/%h", wr_a, nt_a,
                        {1'b1, 4'd7, 1'b1, 16'd50, 16'd1}, {1'b1, 4'd7, 16'd50, 16'd1});
    end
    nxt();
    n_cmp++;
    if ({a_wen, a_lv} !== 2'b00) begin
      n_err++; $display("FAIL fwd_gap actual=%b required=00", {a_wen, a_lv});
    end
    nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd7, 1'b1, 16'd50, 16'd1} || nt_a !== {1'b0, 4'd7, 16'd50, 16'd1}) begin
      n_err++; $display("FAIL fwd_s4_bid actual=%h/%h required=%h/%h", wr_a, nt_a,
                        {1'b1, 4'd7, 1'b1, 16'd50, 16'd1}, {1'b0, 4'd7, 16'd50, 16'd1});
    end
    n_cmp++;
    if (wr_b !== {1'b1, 4'd7, 1'b1, 16'd40, 16'd9} || nt_b !== {1'b1, 4'd7, 16'd40, 16'd9}) begin
      n_err++; $display("FAIL fwd_s4_ask actual=%h/%h required=%h/%h", wr_b, nt_b,
                        {1'b1, 4'd7, 1'b1, 16'd40, 16'd9}, {1'b1, 4'd7, 16'd40, 16'd9});
    end
    nxt(); nxt();
  endtask

  task automatic test_saturate();
    drive(1'b1, 4'd1, 2'd1, 16'd9, 16'hFFF0); nxt();
    drive(1'b1, 4'd1, 2'd1, 16'd9, 16'h0020); nxt();
    idle(); nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd1, 1'b1, 16'd9, 16'hFFF0}) begin
      n_err++; $display("FAIL sat_first actual=%h required=%h", wr_a, {1'b1, 4'd1, 1'b1, 16'd9, 16'hFFF0});
    end
    nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd1, 1'b1, 16'd9, 16'hFFFF} || nt_a !== {1'b1, 4'd1, 16'd9, 16'hFFFF}) begin
      n_err++; $display("FAIL sat_second actual=%h/%h required=%h/%h", wr_a, nt_a,
                        {1'b1, 4'd1, 1'b1, 16'd9, 16'hFFFF}, {1'b1, 4'd1, 16'd9, 16'hFFFF});
    end
    nxt(); nxt();
  endtask

  task automatic test_ascend();
    drive(1'b1, 4'd2, 2'd1, 16'd10, 16'd1); nxt();
    drive(1'b1, 4'd2, 2'd1, 16'd8, 16'd2);  nxt();
    idle(); nxt();
    n_cmp++;
    if (wr_b !== {1'b1, 4'd2, 1'b1, 16'd10, 16'd1}) begin
      n_err++; $display("FAIL asc_first actual=%h required=%h", wr_b, {1'b1, 4'd2, 1'b1, 16'd10, 16'd1});
    end
    nxt();
    n_cmp++;
    if (wr_b !== {1'b1, 4'd2, 1'b1, 16'd8, 16'd2} || nt_b !== {1'b1, 4'd2, 16'd8, 16'd2}) begin
      n_err++; $display("FAIL asc_better actual=%h/%h required=%h/%h", wr_b, nt_b,
                        {1'b1, 4'd2, 1'b1, 16'd8, 16'd2}, {1'b1, 4'd2, 16'd8, 16'd2});
    end
    n_cmp++;
    if (wr_a !== {1'b1, 4'd2, 1'b1, 16'd10, 16'd1} || nt_a !== {1'b0, 4'd2, 16'd10, 16'd1}) begin
      n_err++; $display("FAIL bid_worse actual=%h/%h required=%h/%h", wr_a, nt_a,
                        {1'b1, 4'd2, 1'b1, 16'd10, 16'd1}, {1'b0, 4'd2, 16'd10, 16'd1});
    end
    nxt(); nxt();
  endtask

  task automatic test_del();
    drive(1'b1, 4'd5, 2'd1, 16'd20, 16'd10); nxt();
    drive(1'b1, 4'd5, 2'd2, 16'd30, 16'd3);  nxt();
    drive(1'b1, 4'd5, 2'd2, 16'd20, 16'd3);  nxt();
    drive(1'b1, 4'd5, 2'd2, 16'd20, 16'd7);  nxt();
    idle();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd5, 1'b1, 16'd20, 16'd10} || a_lv !== 1'b0) begin
      n_err++; $display("FAIL del_wrong_key actual=%h/%b required=%h/0", wr_a, a_lv, {1'b1, 4'd5, 1'b1, 16'd20, 16'd10});
    end
    nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd5, 1'b1, 16'd20, 16'd7} || nt_a !== {1'b1, 4'd5, 16'd20, 16'd7}) begin
      n_err++; $display("FAIL del_partial actual=%h/%h required=%h/%h", wr_a, nt_a,
                        {1'b1, 4'd5, 1'b1, 16'd20, 16'd7}, {1'b1, 4'd5, 16'd20, 16'd7});
    end
    nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd5, 33'd0} || nt_a !== {1'b1, 4'd5, 32'd0}) begin
      n_err++; $display("FAIL del_exact actual=%h/%h required=%h/%h", wr_a, nt_a, {1'b1, 4'd5, 33'd0}, {1'b1, 4'd5, 32'd0});
    end
    nxt(); nxt();
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 4'd4, 2'd1, 16'd1, 16'd1); nxt();
    drive(1'b1, 4'd4, 2'd1, 16'd2, 16'd2); nxt();
    drive(1'b1, 4'd4, 2'd1, 16'd3, 16'd3);
    rst = 1'b1;
    nxt();
    idle();
    n_cmp++;
    if ({wr_a, nt_a, a_done, a_s1v, a_s2v, a_s3v, a_s4v} !== '0) begin
      n_err++; $display("FAIL midflight_flush actual=%h required=0", {wr_a, nt_a, a_done, a_s1v, a_s2v, a_s3v, a_s4v});
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nxt();
      n_cmp++;
      if ({wr_a, a_done, a_lv} !== {1'b1, 4'(i), 33'd0, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL reinit_write_%0d actual=%h required=%h", i,
                          {wr_a, a_done, a_lv}, {1'b1, 4'(i), 33'd0, 1'b0, 1'b0});
      end
    end
    nxt();
    n_cmp++;
    if ({a_done, a_wen, a_lv} !== 3'b100) begin
      n_err++; $display("FAIL reinit_done actual=%b required=100", {a_done, a_wen, a_lv});
    end
    drive(1'b1, 4'd4, 2'd1, 16'd0, 16'd1); nxt();
    idle(); nxt(); nxt();
    n_cmp++;
    if (wr_a !== {1'b1, 4'd4, 1'b1, 16'd0, 16'd1} || nt_a !== {1'b1, 4'd4, 16'd0, 16'd1}) begin
      n_err++; $display("FAIL post_reinit_add actual=%h/%h required=%h/%h", wr_a, nt_a,
                        {1'b1, 4'd4, 1'b1, 16'd0, 16'd1}, {1'b1, 4'd4, 16'd0, 16'd1});
    end
    nxt(); nxt();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_clr();
    test_back_to_back();
    test_fwd_s4();
    test_saturate();
    test_ascend();
    test_del();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/v_pipe_update_fwd.md
Name: v_pipe_update_fwd

Overview:
- Parametrised successor to the list update pipeline.
- Accepts one list update per cycle and runs a read-modify-write of the per-product level-0 (best) state in an external state RAM.
- Forwards in-flight writes so back-to-back updates to the same product are correct, and emits a level-0 notify whenever a product's best entry changes.
- Adds a post-reset init sweep that invalidates every state entry.

Parameters:
- ID_W, 4, product id width; state RAM depth is 2**ID_W.
- KEY_W, 16, price key width.
- SIZE_W, 16, size width.
- KEY_ASCEND, 0. 0: best is the largest key (bid side). 1: best is the smallest key (ask side).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- i_upd_vld  in  1  update valid. No backpressure; ignored while o_init_done_r=0.
- i_upd_prod_id  in  ID_W  product id; also the state address.
- i_upd_cmd  in  2  command: 0 CLR, 1 ADD, 2 DEL, 3 REP.
- i_upd_key  in  KEY_W  key.
- i_upd_size  in  SIZE_W  size.
- i_state_rdata  in  1+KEY_W+SIZE_W  state read data {vld,key,size}. Valid the cycle after o_state_ren.
- o_state_ren  out  1  state read enable.
- o_state_raddr  out  ID_W  state read address.
- o_state_wen_r  out  1  state write enable.
- o_state_waddr_r  out  ID_W  state write address.
- o_state_wdata_r  out  1+KEY_W+SIZE_W  state write data.
- o_lv0_vld_r  out  1  notify valid.
- o_lv0_prod_id_r  out  ID_W  notify product id.
- o_lv0_key_r  out  KEY_W  notify key.
- o_lv0_size_r  out  SIZE_W  notify size.
- o_sN_upd_vld_r, o_sN_upd_prod_id_r (N=1..4)  out  1 / ID_W  per-stage occupancy, for external collision checks.
- o_init_done_r  out  1  init sweep complete.

Behaviour:
- Reset: all outputs 0, all stage valids 0, FSM to INIT. In-flight updates are dropped and no write is issued after rst.
- FSM INIT:
  - Address counter runs 0..2**ID_W-1, one write per cycle of wdata=0 (invalid), wen_r=1.
  - Go to RUN after the last address.
  - o_init_done_r rises on the first RUN cycle. Total sweep is 2**ID_W cycles after rst deasserts.
  - No notifies are issued in INIT.
- RUN pipeline; update accepted at cycle T:
  - S1 (T+1): o_state_ren=1, o_state_raddr=prod_id. o_state_ren and o_state_raddr are combinational from S1.
  - S2 (T+2): rdata returns. Effective old state is chosen by priority: S3 write register if same id, else S4 (write delayed one cycle) if same id, else RAM rdata. The next state is computed.
  - S3 (T+3): o_state_wen_r=1 with waddr=id and wdata=next state. o_lv0_* is valid this same cycle if the state changed.
  - S4 (T+4): copy of the S3 write, held for forwarding only.
- RAM model:
  - Read-old on same-cycle read/write to the same address.
  - Write commits at the edge ending the wen_r cycle.
- Commands (old = {v,k,s}; "better" means > for KEY_ASCEND=0, < for KEY_ASCEND=1):
  - CLR: next = 0.
  - REP: next = {1,key,size}.
  - ADD, when !v or key better than k: next = {1,key,size}.
  - ADD, when v and key==k: next = {1,k,min(s+size, 2**SIZE_W-1)} (saturating).
  - ADD, otherwise: unchanged.
  - DEL, when v and key==k and size>=s: next = 0.
  - DEL, when v and key==k and size<s: next = {1,k,s-size}.
  - DEL, otherwise: unchanged.
  - A zero-size ADD or REP is legal and stored as given.
- Write rule: the write is issued on every RUN update, even when the state is unchanged.
- Notify rule:
  - o_lv0_vld_r=1 only when next != old.
  - key and size are taken from next; both are 0 when next is invalid.
  - Notify fields hold their last value when vld=0.
- Throughput: 1 update per cycle. Same-id updates on consecutive cycles resolve in arrival order via forwarding.

Optional Feature:
- Macro V_PIPE_UPDATE_FWD_STATS_EN.
- When defined, adds output ports:
  - o_stat_upd_cnt_r (32): increments per update accepted into S1.
  - o_stat_ntf_cnt_r (32): increments per o_lv0_vld_r pulse.
  - Both counters wrap modulo 2**32, are cleared by rst, and do not count during INIT.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset/init, ID_W=4: release rst -> 16 consecutive writes, addr 0..15, wdata=0. o_init_done_r=1 on cycle 17. No lv0 pulses.
- Basic ADD: id=3, ADD key=100 size=5 -> wen_r at T+3 with {1,100,5}; lv0 {3,100,5} at T+3.
- Back-to-back forwarding on id=3: ADD key=100 size=5, then ADD key=100 size=7 on the next cycle, then DEL key=100 size=12 on the cycle after -> writes {1,100,5}, {1,100,12}, 0; three lv0 pulses, the last with key=0 size=0.
- Forward distance 2 (via S4) on id=7: REP key=50 size=1, one idle cycle, then ADD key=40 size=9 -> second write {1,50,1}; no second notify.
- Saturation: id=1, ADD key=9 size=0xFFF0, then ADD key=9 size=0x20 -> size 0xFFFF. KEY_ASCEND=1 variant: ADD key=10, then key=8 -> best becomes 8.
- Reset mid-flight: three updates issued, rst asserted at T+2 -> no wen_r and no lv0 from those updates. Init sweep restarts.
